// File: rtl/uart16550_fifo.sv
// 16550-compatible UART register block: RX/TX byte FIFOs, trigger-level and
// character-timeout interrupts, decoded at an 8-byte aligned I/O base.
module uart16550_fifo #(
  parameter logic [11:0] BASE_ADDR      = 12'h3F8,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [19:0] iAddr,
  input  logic        iWr,
  input  logic [7:0]  iWrData,
  input  logic        iRd,
  output logic [7:0]  oRdData,
  output logic        oSel,
  output logic        oIntr,
  input  logic [7:0]  iRxData,
  input  logic        iRx,
  output logic        oRxReady,
  output logic        oRxTaken,
  input  logic        iTxReady,
  output logic [7:0]  oTxData,
  output logic        oTx,
  output logic        oDTR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ID_NONE = 3'b000,
    ID_THRE = 3'b001,
    ID_RDA  = 3'b010,
    ID_LS   = 3'b011,
    ID_CTI  = 3'b110
  } int_id_e;

  logic [3:0]  ier;
  logic [7:0]  lcr, scr, dll, dlm;
  logic [4:0]  mcr;
  logic        fifo_en;
  logic [1:0]  rx_trig_sel;
  logic        oe, thre_pend;
  logic [TW-1:0] to_cnt;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [CW-1:0] rx_count, tx_count, rx_count_nxt, tx_count_nxt;

  // Upper address lines are don't-care: the block aliases through the 20-bit space.
  logic       sel;
  logic [2:0] off;
  assign sel = (iAddr[11:3] == BASE_ADDR[11:3]) & (|{1'b1, iAddr[19:12]});
  assign off = iAddr[2:0];

  logic dlab, wr_en, rd_en;
  assign dlab  = lcr[7];
  assign wr_en = iWr & sel;
  assign rd_en = iRd & sel;

  logic fcr_wr, en_change, rx_clr, tx_clr, ier_wr, lsr_rd, iir_rd;
  assign fcr_wr    = wr_en & (off == 3'd2);
  assign en_change = fcr_wr & (iWrData[0] != fifo_en);
  assign rx_clr    = fcr_wr & (iWrData[1] | en_change);
  assign tx_clr    = fcr_wr & (iWrData[2] | en_change);
  assign ier_wr    = wr_en & (off == 3'd1) & !dlab;
  assign lsr_rd    = rd_en & (off == 3'd5);
  assign iir_rd    = rd_en & (off == 3'd2);

  logic [CW-1:0] depth_eff, depth_nxt;
  assign depth_eff = fifo_en ? CW'(FIFO_DEPTH) : CW'(1);
  assign depth_nxt = (fcr_wr ? iWrData[0] : fifo_en) ? CW'(FIFO_DEPTH) : CW'(1);

  logic rx_empty, rx_full, tx_empty, tx_full;
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count >= depth_eff);
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count >= depth_eff);

  // A full FIFO still takes a byte when a pop frees a slot in the same cycle.
  logic rx_pop, rx_push, rx_drop, tx_push_req, tx_push, tx_pop;
  assign rx_pop      = rd_en & (off == 3'd0) & !dlab & !rx_empty;
  assign rx_push     = iRx & (!rx_full | rx_pop);
  assign rx_drop     = iRx & rx_full & !rx_pop;
  assign tx_pop      = iTxReady & !tx_empty;
  assign tx_push_req = wr_en & (off == 3'd0) & !dlab;
  assign tx_push     = tx_push_req & (!tx_full | tx_pop);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rx_count_nxt = rx_count;
    tx_count_nxt = tx_count;
    if (rx_clr)                 rx_count_nxt = '0;
    else if (rx_push & !rx_pop) rx_count_nxt = rx_count + CW'(1);
    else if (!rx_push & rx_pop) rx_count_nxt = rx_count - CW'(1);
    if (tx_clr)                 tx_count_nxt = '0;
    else if (tx_push & !tx_pop) tx_count_nxt = tx_count + CW'(1);
    else if (!tx_push & tx_pop) tx_count_nxt = tx_count - CW'(1);
  end

  logic [CW-1:0] rx_trig;
  always_comb begin
    rx_trig = CW'(1);
    case (rx_trig_sel)
      2'b01:   rx_trig = CW'(FIFO_DEPTH / 4);
      2'b10:   rx_trig = CW'(FIFO_DEPTH / 2);
      2'b11:   rx_trig = CW'(FIFO_DEPTH - 2);
      default: rx_trig = CW'(1);
    endcase
  end

  logic    cti, pending;
  int_id_e int_id;
  assign cti = fifo_en & (to_cnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    int_id = ID_NONE;
    if (ier[2] & oe)                           int_id = ID_LS;
    else if (ier[0] & (rx_count >= rx_trig))   int_id = ID_RDA;
    else if (ier[0] & cti)                     int_id = ID_CTI;
    else if (ier[1] & thre_pend)               int_id = ID_THRE;
  end
  assign pending = (int_id != ID_NONE);

  logic [7:0] iir, lsr, rd_val;
  assign iir = {fifo_en, fifo_en, 2'b00, int_id, !pending};
  assign lsr = {1'b0, tx_empty & !oTx, tx_empty, 3'b000, oe, !rx_empty};

  always_comb begin
    rd_val = 8'h00;
    case (off)
      3'd0:    rd_val = dlab ? dll : (rx_empty ? 8'h00 : rx_mem[rx_rp]);
      3'd1:    rd_val = dlab ? dlm : {4'b0000, ier};
      3'd2:    rd_val = iir;
      3'd3:    rd_val = lcr;
      3'd4:    rd_val = {3'b000, mcr};
      3'd5:    rd_val = lsr;
      3'd7:    rd_val = scr;
      default: rd_val = 8'h00;
    endcase
  end

  logic thre_set, thre_clr;
  assign thre_set = (!tx_empty & (tx_count_nxt == '0)) |
                    (ier_wr & iWrData[1] & !ier[1] & tx_empty);
  assign thre_clr = tx_push_req | (iir_rd & (int_id == ID_THRE));

  // NOTE: the FIFO storage has no reset; the pointers and counts define which
  // entries are valid, so a reset only needs to clear those.
  always_ff @(posedge iClk) begin
    if (rx_push) rx_mem[rx_wp] <= iRxData;
    if (tx_push) tx_mem[tx_wp] <= iWrData;
  end

  // NOTE: all state below uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ier <= '0; lcr <= '0; mcr <= '0; scr <= '0; dll <= '0; dlm <= '0;
      fifo_en <= 1'b0; rx_trig_sel <= 2'b00;
      oe <= 1'b0; thre_pend <= 1'b0; to_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; tx_wp <= '0; tx_rp <= '0;
      rx_count <= '0; tx_count <= '0;
      oRdData <= '0; oSel <= 1'b0; oIntr <= 1'b0;
      oRxReady <= 1'b0; oRxTaken <= 1'b0; oTxData <= '0; oTx <= 1'b0;
    end else begin
      if (wr_en) begin
        case (off)
          3'd0: if (dlab) dll <= iWrData;
          3'd1: if (dlab) dlm <= iWrData; else ier <= iWrData[3:0];
          3'd2: begin fifo_en <= iWrData[0]; rx_trig_sel <= iWrData[7:6]; end
          3'd3: lcr <= iWrData;
          3'd4: mcr <= iWrData[4:0];
          3'd7: scr <= iWrData;
          default: ;
        endcase
      end

      rx_count <= rx_count_nxt;
      tx_count <= tx_count_nxt;
      if (rx_clr) begin
        rx_wp <= '0; rx_rp <= '0;
      end else begin
        if (rx_push) rx_wp <= rx_wp + AW'(1);
        if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      end
      if (tx_clr) begin
        tx_wp <= '0; tx_rp <= '0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + AW'(1);
        if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      end

      oRxReady <= (rx_count_nxt < depth_nxt);
      oRxTaken <= rx_push & !rx_clr;
      oTx      <= tx_pop & !tx_clr;
      if (tx_pop & !tx_clr) oTxData <= tx_mem[tx_rp];

      if (fcr_wr & iWrData[1]) oe <= 1'b0;
      else if (rx_drop)        oe <= 1'b1;
      else if (lsr_rd)         oe <= 1'b0;

      if (rx_push | rx_pop | rx_empty)       to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TW'(1);

      if (thre_set)      thre_pend <= 1'b1;
      else if (thre_clr) thre_pend <= 1'b0;

      oSel <= rd_en;
      if (iRd) oRdData <= sel ? rd_val : 8'hFF;
      oIntr <= pending;
    end
  end

  assign oDTR = mcr[0];

endmodule

// File: tb/tb_uart16550_fifo.sv
// Directed and randomized bench for uart16550_fifo, checked against a
// queue-based model of the RX/TX FIFOs and the line-status flags.
module tb_uart16550_fifo;

  localparam logic [19:0] BASE  = 20'h003F8;
  localparam int          DEPTH = 16;
  localparam int          TMO   = 200;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [19:0] iAddr = '0;
  logic        iWr = 1'b0, iRd = 1'b0, iRx = 1'b0, iTxReady = 1'b0;
  logic [7:0]  iWrData = '0, iRxData = '0;
  logic [7:0]  oRdData, oTxData;
  logic        oSel, oIntr, oRxReady, oRxTaken, oTx, oDTR;

  uart16550_fifo #(.BASE_ADDR(12'h3F8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .iClk(iClk), .iRst(iRst), .iAddr(iAddr), .iWr(iWr), .iWrData(iWrData),
    .iRd(iRd), .oRdData(oRdData), .oSel(oSel), .oIntr(oIntr),
    .iRxData(iRxData), .iRx(iRx), .oRxReady(oRxReady), .oRxTaken(oRxTaken),
    .iTxReady(iTxReady), .oTxData(oTxData), .oTx(oTx), .oDTR(oDTR)
  );

  always #5 iClk = ~iClk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_oe = 1'b0;
  bit         m_en = 1'b0;
  int         m_depth = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    iAddr = BASE + {17'b0, off};
    iWrData = d;
    iWr = 1'b1;
    tick();
    iWr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    iAddr = BASE + {17'b0, off};
    iRd = 1'b1;
    tick();
    iRd = 1'b0;
    d = oRdData;
    check("osel", {31'b0, oSel}, 32'd1);
  endtask

  task automatic rd_chk(input logic [2:0] off, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    rd(off, d);
    check(tag, {24'b0, d}, {24'b0, exp});
  endtask

  task automatic push(input logic [7:0] b);
    iRxData = b;
    iRx = 1'b1;
    tick();
    iRx = 1'b0;
    if (rx_q.size() < m_depth) begin
      rx_q.push_back(b);
      check("rx_taken", {31'b0, oRxTaken}, 32'd1);
    end else begin
      m_oe = 1'b1;
      check("rx_drop_taken", {31'b0, oRxTaken}, 32'd0);
    end
  endtask

  task automatic rbr_read(input string tag);
    logic [7:0] e;
    e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
    rd_chk(3'd0, e, tag);
  endtask

  task automatic lsr_read(input string tag);
    logic [7:0] e;
    e = {1'b0, tx_q.size() == 0, tx_q.size() == 0, 3'b000, m_oe, rx_q.size() != 0};
    rd_chk(3'd5, e, tag);
    m_oe = 1'b0;
  endtask

  task automatic fcr(input logic [7:0] d);
    wr(3'd2, d);
    if (d[0] != m_en) begin rx_q.delete(); tx_q.delete(); end
    if (d[1]) begin rx_q.delete(); m_oe = 1'b0; end
    if (d[2]) tx_q.delete();
    m_en = d[0];
    m_depth = d[0] ? DEPTH : 1;
  endtask

  task automatic thr_write(input logic [7:0] b);
    wr(3'd0, b);
    if (tx_q.size() < m_depth) tx_q.push_back(b);
  endtask

  task automatic drain_tx(input int cycles, input int exp_pulses, input string tag);
    int pulses = 0;
    iTxReady = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (oTx) begin
        pulses++;
        check({tag, "_data"}, {24'b0, oTxData}, {24'b0, (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx});
      end
    end
    iTxReady = 1'b0;
    check({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] d, head, b;
    int n;

    // Reset values
    #2 iRst = 1'b1;
    #5;
    check("rst_rddata", {24'b0, oRdData}, 32'd0);
    check("rst_sel",    {31'b0, oSel},    32'd0);
    check("rst_intr",   {31'b0, oIntr},   32'd0);
    check("rst_rxrdy",  {31'b0, oRxReady}, 32'd0);
    check("rst_taken",  {31'b0, oRxTaken}, 32'd0);
    check("rst_txdata", {24'b0, oTxData}, 32'd0);
    check("rst_tx",     {31'b0, oTx},     32'd0);
    check("rst_dtr",    {31'b0, oDTR},    32'd0);
    @(negedge iClk) iRst = 1'b0;
    tick();
    check("rxrdy_after_rst", {31'b0, oRxReady}, 32'd1);
    rd_chk(3'd2, 8'h01, "iir_rst");
    lsr_read("lsr_rst");

    // RX trigger level 4
    fcr(8'h41);
    wr(3'd1, 8'h01);
    for (int i = 0; i < 3; i++) push(8'($urandom));
    check("intr_below_trig", {31'b0, oIntr}, 32'd0);
    push(8'($urandom));
    check("intr_latency", {31'b0, oIntr}, 32'd0);
    tick();
    check("intr_at_trig", {31'b0, oIntr}, 32'd1);
    rd_chk(3'd2, 8'hC4, "iir_rda");
    for (int i = 0; i < 4; i++) rbr_read("rbr_trig");
    tick();
    check("intr_drop", {31'b0, oIntr}, 32'd0);

    // Overflow with held iRx
    for (int i = 0; i < 17; i++) begin
      push(8'($urandom));
      if (i == 14) check("rxrdy_15", {31'b0, oRxReady}, 32'd1);
      if (i == 15) check("rxrdy_full", {31'b0, oRxReady}, 32'd0);
    end
    wr(3'd1, 8'h04);
    tick();
    check("intr_ls", {31'b0, oIntr}, 32'd1);
    rd_chk(3'd2, 8'hC6, "iir_ls");
    lsr_read("lsr_oe");
    lsr_read("lsr_oe_clr");
    rd_chk(3'd2, 8'hC1, "iir_ls_clr");
    for (int i = 0; i < 16; i++) rbr_read("rbr_ovf");
    rbr_read("rbr_empty");

    // Randomized push/read/status traffic
    wr(3'd1, 8'h00);
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0, 1: push(8'($urandom));
        2:    rbr_read("rbr_rand");
        default: lsr_read("lsr_rand");
      endcase
    end
    while (rx_q.size() != 0) rbr_read("rbr_rand_drain");
    lsr_read("lsr_rand_end");

    // Push and pop in the same cycle on a full FIFO
    while (rx_q.size() < DEPTH) push(8'($urandom));
    b = 8'($urandom);
    head = rx_q.pop_front();
    rx_q.push_back(b);
    iAddr = BASE;
    iRd = 1'b1;
    iRxData = b;
    iRx = 1'b1;
    tick();
    iRd = 1'b0;
    iRx = 1'b0;
    check("pp_data",  {24'b0, oRdData}, {24'b0, head});
    check("pp_taken", {31'b0, oRxTaken}, 32'd1);
    check("pp_rxrdy", {31'b0, oRxReady}, 32'd0);
    lsr_read("lsr_pp_no_oe");
    for (int i = 0; i < DEPTH; i++) rbr_read("rbr_pp");

    // Character timeout, trigger 14
    fcr(8'hC1);
    wr(3'd1, 8'h01);
    push(8'($urandom));
    push(8'($urandom));
    n = 0;
    repeat (TMO / 2 - 1) begin tick(); n++; end
    rd_chk(3'd2, 8'hC1, "iir_pre_cti");
    n++;
    check("intr_pre_cti", {31'b0, oIntr}, 32'd0);
    while (!oIntr && n < TMO + 20) begin tick(); n++; end
    check("cti_cycles", n, TMO + 1);
    rd_chk(3'd2, 8'hCC, "iir_cti");
    rbr_read("rbr_cti");
    rd_chk(3'd2, 8'hC1, "iir_cti_clr");
    check("intr_cti_clr", {31'b0, oIntr}, 32'd0);
    n = 1;
    while (!oIntr && n < TMO + 20) begin tick(); n++; end
    check("cti_restart_cycles", n, TMO + 1);
    rd_chk(3'd2, 8'hCC, "iir_cti2");
    rbr_read("rbr_cti2");
    tick();
    check("intr_cti_end", {31'b0, oIntr}, 32'd0);

    // THRE interrupt
    fcr(8'h07);
    wr(3'd1, 8'h02);
    tick();
    check("intr_thre_en", {31'b0, oIntr}, 32'd1);
    rd_chk(3'd2, 8'hC2, "iir_thre_en");
    rd_chk(3'd2, 8'hC1, "iir_thre_en_clr");
    for (int i = 0; i < 3; i++) thr_write(8'($urandom));
    lsr_read("lsr_tx_busy");
    check("intr_tx_busy", {31'b0, oIntr}, 32'd0);
    drain_tx(12, 3, "tx3");
    check("intr_thre", {31'b0, oIntr}, 32'd1);
    rd_chk(3'd2, 8'hC2, "iir_thre");
    rd_chk(3'd2, 8'hC1, "iir_thre_clr");
    lsr_read("lsr_tx_idle");

    // 8250 mode: single-entry FIFOs
    fcr(8'h00);
    thr_write(8'($urandom));
    thr_write(8'($urandom));
    drain_tx(6, 1, "tx_8250");
    rd_chk(3'd2, 8'h02, "iir_thre_8250");
    wr(3'd1, 8'h00);
    rd_chk(3'd2, 8'h01, "iir_8250_idle");
    push(8'($urandom));
    push(8'($urandom));
    lsr_read("lsr_8250_oe");
    rbr_read("rbr_8250");
    rbr_read("rbr_8250_empty");

    // Divisor latch, MCR, SCR, MSR, decode
    wr(3'd3, 8'h83);
    wr(3'd0, 8'h0C);
    wr(3'd1, 8'h00);
    rd_chk(3'd0, 8'h0C, "dll");
    rd_chk(3'd1, 8'h00, "dlm");
    rd_chk(3'd3, 8'h83, "lcr");
    wr(3'd3, 8'h03);
    lsr_read("lsr_after_dll");
    wr(3'd4, 8'hFF);
    check("dtr", {31'b0, oDTR}, 32'd1);
    rd_chk(3'd4, 8'h1F, "mcr");
    wr(3'd7, 8'hA5);
    rd_chk(3'd7, 8'hA5, "scr");
    rd_chk(3'd6, 8'h00, "msr");
    wr(3'd5, 8'hFF);
    lsr_read("lsr_ro");
    iAddr = 20'h00400;
    iRd = 1'b1;
    tick();
    iRd = 1'b0;
    check("undec_data", {24'b0, oRdData}, 32'h0000_00FF);
    check("undec_sel",  {31'b0, oSel},    32'd0);
    iAddr = 20'hF03FF;
    iRd = 1'b1;
    tick();
    iRd = 1'b0;
    check("alias_data", {24'b0, oRdData}, 32'h0000_00A5);
    check("alias_sel",  {31'b0, oSel},    32'd1);

    // Asynchronous reset mid-run discards state
    push(8'($urandom));
    #2 iRst = 1'b1;
    #1;
    check("arst_dtr",   {31'b0, oDTR},     32'd0);
    check("arst_rxrdy", {31'b0, oRxReady}, 32'd0);
    @(negedge iClk) iRst = 1'b0;
    tick();
    rx_q.delete(); tx_q.delete(); m_oe = 1'b0; m_en = 1'b0; m_depth = 1;
    lsr_read("lsr_arst");
    rd_chk(3'd2, 8'h01, "iir_arst");
    rd_chk(3'd7, 8'h00, "scr_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart16550_fifo.md
Name: uart16550_fifo

Overview:
- 16550-compatible UART register block with parametrised RX/TX FIFOs, trigger-level and character-timeout interrupts, and a configurable I/O base address.
- Successor to the 8250-style UART in the ISA I/O map; same CPU-side and byte-stream-side handshakes.
- Serial bit timing is external; this block only moves bytes between the bus registers and the host-side byte stream.

Parameters:
- BASE_ADDR, 12'h3F8: I/O base, 8-byte aligned; decode is iAddr[11:3]=BASE_ADDR[11:3].
- FIFO_DEPTH, 16: RX and TX FIFO entries; power of two, 4 to 256.
- TIMEOUT_CYCLES, 4096: idle iClk cycles before a character-timeout interrupt; at least 2.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset; asynchronous, active-high.
- iAddr  in  20  I/O address.
- iWr  in  1  write strobe, one cycle per access.
- iWrData  in  8  write data.
- iRd  in  1  read strobe, one cycle per access.
- oRdData  out  8  read data, registered.
- oSel  out  1  one-cycle pulse marking a decoded read.
- oIntr  out  1  level interrupt request.
- iRxData  in  8  incoming byte.
- iRx  in  1  incoming byte valid.
- oRxReady  out  1  RX FIFO can accept a byte.
- oRxTaken  out  1  one-cycle pulse per accepted byte.
- iTxReady  in  1  sink can accept a byte.
- oTxData  out  8  outgoing byte.
- oTx  out  1  one-cycle pulse, oTxData valid.
- oDTR  out  1  MCR[0].

Behaviour:
- Reset, asynchronous:
  - All outputs 0.
  - IER, LCR, MCR, SCR, DLL, DLM = 0; FCR = 0.
  - FIFOs empty; OE=0; timeout counter=0.
  - Reset at any point discards FIFO contents.
- Effective depth: FIFO_DEPTH when FCR[0]=1, otherwise 1 (8250 mode).
- Register map by iAddr[2:0]:
  - 0: DLAB=1 reads/writes DLL. DLAB=0 write pushes TX; read pops RX.
  - 1: DLAB=1 reads/writes DLM. DLAB=0 is IER[3:0].
  - 2: read IIR; write FCR.
  - 3: LCR. 4: MCR[4:0]. 5: LSR, read-only; writes ignored.
  - 6: MSR, reads 8'h00. 7: SCR.
- Reads:
  - oRdData and oSel are valid the cycle after iRd; undecoded offsets return 8'hFF.
  - Side effects apply once, in the iRd cycle.
  - RBR read on an empty RX FIFO returns 8'h00 and does not pop.
- FCR write:
  - bit0 FIFO enable; any change of bit0 clears both FIFOs.
  - bit1 clears RX FIFO and OE; bit2 clears TX FIFO.
  - bits[7:6] set the RX trigger: 00→1, 01→DEPTH/4, 10→DEPTH/2, 11→DEPTH-2.
  - A clear overrides any push or pop in the same cycle.
- RX path:
  - oRxReady = !rx_full.
  - iRx while not full: push, oRxTaken=1 next cycle.
  - iRx while full: byte dropped, OE=1, no oRxTaken.
  - Push and CPU pop in the same cycle: both take effect; a full FIFO accepts the byte.
- TX path:
  - THR write while TX full: byte dropped.
  - iTxReady with TX non-empty: pop head; next cycle oTx=1 and oTxData=head.
  - A push and a drain in the same cycle are both honoured.
- LSR = {1'b0, TEMT, THRE, 3'b000, OE, DR}:
  - DR = RX non-empty. THRE = TX empty. TEMT = THRE & !oTx.
  - An LSR read clears OE.
- Timeout counter:
  - Resets on RX push, RX pop, or RX empty; otherwise increments, saturating at TIMEOUT_CYCLES.
  - cti = FCR[0] & (count==TIMEOUT_CYCLES).
- THRE pending flag:
  - Set on the TX non-empty→empty transition, and on an IER[1] 0→1 write while TX is empty.
  - Cleared by a THR write, or by an IIR read that reports THRE.
- Interrupt priority, highest first:
  - Line status: IER[2]&OE, ID 3'b011.
  - RX data: IER[0]&(rx_count≥trigger), ID 3'b010.
  - Char timeout: IER[0]&cti, ID 3'b110.
  - THRE: IER[1]&thre_pend, ID 3'b001.
- IIR = {FCR[0],FCR[0],2'b00,ID,!pending}; no source pending reads 8'h01 or 8'hC1.
- oIntr is registered, = pending, and updates one cycle after its sources change.

Test Plan:
- Reset, then read offsets 2 and 5 → 8'h01, then 8'h60; all outputs 0.
- FCR=8'h41 (DEPTH 16, trigger 4), IER=1; push 3 bytes → oIntr stays 0. Push a 4th → oIntr=1 two cycles later; IIR=8'hC4. Read 4 RBR bytes → data in order; oIntr drops.
- FIFO on: push 17 bytes with iRx held → oRxReady=0 after 16; 17th dropped, no oRxTaken. With IER=4: LSR=8'h63, IIR=8'hC6. Read LSR → OE cleared.
- FIFO on, IER=1, trigger 14; push 2 bytes, idle → after TIMEOUT_CYCLES, IIR=8'hCC. Read one byte → timeout clears, counter restarts.
- IER=2, write 3 bytes, hold iTxReady=1 → 3 oTx pulses in order; THRE interrupt (IIR=8'hC2). Read IIR → pending cleared.
- FIFO off: two iRx bytes without a read → second dropped and OE=1. DLAB=1: write DLL=8'h0C, DLM=8'h00 → read back 8'h0C, 8'h00.
